// File: rtl/vga_obj_pkg.sv
// vga_obj_pkg: shared VGA defaults, colour constants and bounce direction encoding
package vga_obj_pkg;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    localparam logic [11:0] WHITE = 12'hFFF;
    // bit 1 = moving up, bit 0 = moving left
    typedef enum logic [1:0] {DR = 2'd0, DL = 2'd1, UR = 2'd2, UL = 2'd3} dir_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every DIV clocks
module tick_gen #(
    parameter int DIV = 262144
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt;
    assign tick = cnt == CW'(DIV - 1);
    // count 0..DIV-1 and wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/vga_obj_engine.sv
// vga_obj_engine: border plus one moving rectangle, manual or bouncing, with edge-hit pulse
module vga_obj_engine
    import vga_obj_pkg::*;
#(
    parameter int          H_RES    = H_RES_DEF,
    parameter int          V_RES    = V_RES_DEF,
    parameter int          COORD_W  = 10,
    parameter int          OBJ_W    = 30,
    parameter int          OBJ_H    = 30,
    parameter int          BORDER   = 10,
    parameter int          STEP     = 1,
    parameter int          TICK_DIV = 262144,
    parameter int          WRAP     = 0,
    parameter logic [11:0] OBJ_RGB  = 12'h0F0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_switch,
    input  logic               dn_switch,
    input  logic               left_switch,
    input  logic               right_switch,
    input  logic               auto_mode,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               blank,
    output logic [3:0]         RED,
    output logic [3:0]         GREEN,
    output logic [3:0]         BLUE,
    output logic [COORD_W-1:0] obj_x,
    output logic [COORD_W-1:0] obj_y,
    output logic               hit
);
    // two guard bits keep candidates from silently wrapping below 0 or above the range
    localparam int SW = COORD_W + 2;
    localparam logic signed [SW-1:0] LO   = SW'(BORDER);
    localparam logic signed [SW-1:0] HI_X = SW'(H_RES - BORDER - OBJ_W);
    localparam logic signed [SW-1:0] HI_Y = SW'(V_RES - BORDER - OBJ_H);
    localparam logic signed [SW-1:0] STP  = SW'(STEP);
    localparam logic [COORD_W-1:0] X0  = COORD_W'((H_RES - OBJ_W) / 2);
    localparam logic [COORD_W-1:0] Y0  = COORD_W'((V_RES - OBJ_H) / 2);
    localparam logic [COORD_W-1:0] BL  = COORD_W'(BORDER);
    localparam logic [COORD_W-1:0] BHX = COORD_W'(H_RES - BORDER);
    localparam logic [COORD_W-1:0] BHY = COORD_W'(V_RES - BORDER);
    localparam logic [COORD_W:0]   OW  = (COORD_W + 1)'(OBJ_W);
    localparam logic [COORD_W:0]   OH  = (COORD_W + 1)'(OBJ_H);

    logic tick;
    dir_t state, state_nx;
    logic signed [SW-1:0] px, py, dx, dy;
    logic [COORD_W-1:0] nx, ny;
    logic hx, hy, border, in_obj;
    logic [11:0] rgb;

    tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

    // manual axis: clamp or wrap a candidate; MSB of result flags an edge hit
    function automatic logic [COORD_W:0] man_axis(input logic signed [SW-1:0] c, input logic signed [SW-1:0] hi);
        if (c < LO) return {1'b1, (WRAP != 0) ? hi[COORD_W-1:0] : LO[COORD_W-1:0]};
        if (c > hi) return {1'b1, (WRAP != 0) ? LO[COORD_W-1:0] : hi[COORD_W-1:0]};
        return {1'b0, c[COORD_W-1:0]};
    endfunction

    // bounce axis: step in the current direction, stop on the limit; MSB flags hit and flip
    function automatic logic [COORD_W:0] bnc_axis(input logic signed [SW-1:0] p, input logic neg, input logic signed [SW-1:0] hi);
        logic signed [SW-1:0] c;
        c = neg ? p - STP : p + STP;
        if (neg ? c <= LO : c >= hi) return {1'b1, neg ? LO[COORD_W-1:0] : hi[COORD_W-1:0]};
        return {1'b0, c[COORD_W-1:0]};
    endfunction

    // next position, hit flags and next bounce direction
    always_comb begin
        px = {2'b00, obj_x};
        py = {2'b00, obj_y};
        dx = (right_switch & ~left_switch) ? STP : (left_switch & ~right_switch) ? -STP : '0;
        dy = (dn_switch & ~up_switch) ? STP : (up_switch & ~dn_switch) ? -STP : '0;
        {hx, nx} = auto_mode ? bnc_axis(px, state[0], HI_X) : man_axis(px + dx, HI_X);
        {hy, ny} = auto_mode ? bnc_axis(py, state[1], HI_Y) : man_axis(py + dy, HI_Y);
        state_nx = auto_mode ? dir_t'(state ^ {hy, hx}) : state;
    end

    // position, direction and hit registers advance only on tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obj_x <= X0;
            obj_y <= Y0;
            state <= DR;
            hit   <= 1'b0;
        end else begin
            hit <= tick & (hx | hy);
            if (tick) begin
                obj_x <= nx;
                obj_y <= ny;
                state <= state_nx;
            end
        end
    end

    assign border = x < BL || x >= BHX || y < BL || y >= BHY;
    assign in_obj = x >= obj_x && {1'b0, x} < {1'b0, obj_x} + OW &&
                    y >= obj_y && {1'b0, y} < {1'b0, obj_y} + OH;

    // registered colour mux: blank, then border, then object
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= '0;
        else        rgb <= blank ? '0 : border ? WHITE : in_obj ? OBJ_RGB : '0;
    end

    assign RED   = rgb[11:8];
    assign GREEN = rgb[7:4];
    assign BLUE  = rgb[3:0];
endmodule

// File: tb/tb_vga_obj_engine.sv
// tb_vga_obj_engine: clamp and wrap instances checked every cycle against a tick-level model
module tb_vga_obj_engine;
    localparam int TD = 4, MINV = 10, MAXX = 600, MAXY = 440, X0 = 305, Y0 = 225;

    logic clk = 1'b0, rst_n = 1'b1;
    logic up_sw = 1'b0, dn_sw = 1'b0, lf_sw = 1'b0, rt_sw = 1'b0, auto_mode = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic blank = 1'b1;
    logic [3:0] r [2], g [2], b [2];
    logic [9:0] ox [2], oy [2];
    logic hit [2];

    int total = 0, bad = 0;
    int mx [2], my [2], vd [2], hd [2], cnt_m;
    logic [11:0] e_rgb [2];
    logic e_hit [2];

    always #5 clk = ~clk;

    vga_obj_engine #(.TICK_DIV(TD), .WRAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .up_switch(up_sw), .dn_switch(dn_sw), .left_switch(lf_sw),
        .right_switch(rt_sw), .auto_mode(auto_mode), .x(x), .y(y), .blank(blank),
        .RED(r[0]), .GREEN(g[0]), .BLUE(b[0]), .obj_x(ox[0]), .obj_y(oy[0]), .hit(hit[0]));

    vga_obj_engine #(.TICK_DIV(TD), .WRAP(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .up_switch(up_sw), .dn_switch(dn_sw), .left_switch(lf_sw),
        .right_switch(rt_sw), .auto_mode(auto_mode), .x(x), .y(y), .blank(blank),
        .RED(r[1]), .GREEN(g[1]), .BLUE(b[1]), .obj_x(ox[1]), .obj_y(oy[1]), .hit(hit[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] col(input int xx, input int yy, input logic bl, input int px, input int py);
        if (bl) return 12'h000;
        if (xx < 10 || xx >= 630 || yy < 10 || yy >= 470) return 12'hFFF;
        if (xx >= px && xx < px + 30 && yy >= py && yy < py + 30) return 12'h0F0;
        return 12'h000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mx[i] = X0; my[i] = Y0; vd[i] = 1; hd[i] = 1;
            e_hit[i] = 1'b0; e_rgb[i] = 12'h000;
        end
        cnt_m = 0;
    endtask

    // one movement tick for instance i (i==1 is the wrapping instance)
    task automatic adv(input int i);
        int cx, cy;
        if (auto_mode) begin
            cx = mx[i] + hd[i];
            cy = my[i] + vd[i];
            if (cx >= MAXX) begin cx = MAXX; hd[i] = -1; e_hit[i] = 1'b1; end
            else if (cx <= MINV) begin cx = MINV; hd[i] = 1; e_hit[i] = 1'b1; end
            if (cy >= MAXY) begin cy = MAXY; vd[i] = -1; e_hit[i] = 1'b1; end
            else if (cy <= MINV) begin cy = MINV; vd[i] = 1; e_hit[i] = 1'b1; end
        end else begin
            cx = mx[i] + int'(rt_sw) - int'(lf_sw);
            cy = my[i] + int'(dn_sw) - int'(up_sw);
            if (cx < MINV) begin cx = (i == 1) ? MAXX : MINV; e_hit[i] = 1'b1; end
            else if (cx > MAXX) begin cx = (i == 1) ? MINV : MAXX; e_hit[i] = 1'b1; end
            if (cy < MINV) begin cy = (i == 1) ? MAXY : MINV; e_hit[i] = 1'b1; end
            else if (cy > MAXY) begin cy = (i == 1) ? MINV : MAXY; e_hit[i] = 1'b1; end
        end
        mx[i] = cx;
        my[i] = cy;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("obj_x[%0d]", i), 32'(ox[i]), mx[i]);
            chk($sformatf("obj_y[%0d]", i), 32'(oy[i]), my[i]);
            chk($sformatf("hit[%0d]", i), 32'(hit[i]), 32'(e_hit[i]));
            chk($sformatf("rgb[%0d]", i), 32'({r[i], g[i], b[i]}), 32'(e_rgb[i]));
        end
    endtask

    task automatic step();
        logic tk;
        tk = cnt_m == TD - 1;
        for (int i = 0; i < 2; i++) begin
            e_rgb[i] = col(int'(x), int'(y), blank, mx[i], my[i]);
            e_hit[i] = 1'b0;
            if (tk) adv(i);
        end
        cnt_m = tk ? 0 : cnt_m + 1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic rstep();
        x = $urandom_range(1) ? 10'($urandom_range(0, 1023)) : 10'(mx[0] - 3 + $urandom_range(0, 36));
        y = $urandom_range(1) ? 10'($urandom_range(0, 1023)) : 10'(my[0] - 3 + $urandom_range(0, 36));
        blank = $urandom_range(0, 7) == 0;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // pixel mux with the object at its reset position
        x = 10'd305; y = 10'd225; blank = 1'b0; step();
        chk("pix_obj", 32'({r[0], g[0], b[0]}), 32'h0F0);
        x = 10'd335; step();
        chk("pix_right_of_obj", 32'({r[0], g[0], b[0]}), 32'h000);
        x = 10'd5; step();
        chk("pix_border", 32'({r[0], g[0], b[0]}), 32'hFFF);
        blank = 1'b1; step();
        chk("pix_blank", 32'({r[0], g[0], b[0]}), 32'h000);
        // manual clamp to the right edge
        rt_sw = 1'b1;
        repeat (295 * TD) rstep();
        chk("clamp_x_295", 32'(ox[0]), 600);
        chk("clamp_hit_295", 32'(hit[0]), 0);
        repeat (TD) rstep();
        chk("clamp_x_296", 32'(ox[0]), 600);
        chk("clamp_hit_296", 32'(hit[0]), 1);
        chk("wrap_x_296", 32'(ox[1]), 10);
        lf_sw = 1'b1;
        repeat (2 * TD) rstep();
        chk("cancel_x", 32'(ox[0]), 600);
        chk("cancel_x_w", 32'(ox[1]), 10);
        rt_sw = 1'b0;
        repeat (TD) rstep();
        chk("wrap_left_x", 32'(ox[1]), 600);
        chk("wrap_left_hit", 32'(hit[1]), 1);
        chk("clamp_left_x", 32'(ox[0]), 599);
        // random switches, mode changes and pixels
        for (int n = 0; n < 150 * TD; n++) begin
            if (n % 3 == 0) begin
                {up_sw, dn_sw, lf_sw, rt_sw} = 4'($urandom);
                auto_mode = $urandom_range(0, 4) == 0;
            end
            rstep();
        end
        // bounce from reset
        auto_mode = 1'b1;
        {up_sw, dn_sw, lf_sw, rt_sw} = 4'b0101;
        @(posedge clk);
        #1;
        do_reset();
        repeat (215 * TD) rstep();
        chk("bnc_y_215", 32'(oy[0]), 440);
        chk("bnc_hit_215", 32'(hit[0]), 1);
        chk("bnc_x_215", 32'(ox[0]), 520);
        repeat (TD) rstep();
        chk("bnc_ur_y", 32'(oy[0]), 439);
        chk("bnc_ur_x", 32'(ox[0]), 521);
        repeat ((295 - 216) * TD) rstep();
        chk("bnc_x_295", 32'(ox[0]), 600);
        chk("bnc_y_295", 32'(oy[0]), 360);
        chk("bnc_hit_295", 32'(hit[0]), 1);
        repeat (TD) rstep();
        chk("bnc_ul_x", 32'(ox[0]), 599);
        chk("bnc_ul_y", 32'(oy[0]), 359);
        // reset in the middle of a tick period while travelling UL
        repeat (2) rstep();
        do_reset();
        repeat (TD) rstep();
        chk("post_rst_x", 32'(ox[0]), 306);
        chk("post_rst_y", 32'(oy[0]), 226);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
